// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write-back controller.
// The register file is 2**ADDR_W x DATA_W. Registers 0..NUM_RO-1 hold constants.
// MAX_WAIT is the number of consecutive lost arbitrations after which the
// ALU gets priority over returning loads.
package rf_pkg;

    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int NUM_RO   = 2;
    localparam int MAX_WAIT = 3;
    localparam int WAIT_W   = $clog2(MAX_WAIT + 1);

    typedef logic [ADDR_W-1:0] rf_addr_t;
    typedef logic [DATA_W-1:0] rf_data_t;
    typedef logic [WAIT_W-1:0] wait_cnt_t;

    typedef enum logic {
        LD_PRIO  = 1'b0,
        ALU_PRIO = 1'b1
    } prio_t;

    // True for the constant registers that must never be written.
    function automatic logic is_ro(input rf_addr_t addr);
        return int'(addr) < NUM_RO;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-load scoreboard and RAW hazard lookup.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   set_en_i/set_addr_i load issued: mark destination pending
//   clr_en_i/clr_addr_i load data accepted: clear destination
//   wr_en_i/wr_addr_i   registered write port, a write still in flight
//   rd_addr_a_i/_b_i    decode read addresses
//   pend_mask_o         bit i = load outstanding to register i
//   haz_a_o/haz_b_o     read must stall
//   issue_drop_o        issue targeted a constant register and was ignored
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_en_i,
    input  logic [ADDR_W-1:0]   set_addr_i,
    input  logic                clr_en_i,
    input  logic [ADDR_W-1:0]   clr_addr_i,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [ADDR_W-1:0]   rd_addr_a_i,
    input  logic [ADDR_W-1:0]   rd_addr_b_i,
    output logic [NUM_REGS-1:0] pend_mask_o,
    output logic                haz_a_o,
    output logic                haz_b_o,
    output logic                issue_drop_o
);

    logic [NUM_REGS-1:0] pend_q, pend_d;

    assign issue_drop_o = set_en_i && is_ro(set_addr_i);

    // NOTE: every variable written in always_comb gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        pend_d = pend_q;
        if (clr_en_i) begin
            pend_d[clr_addr_i] = 1'b0;
        end
        // Applied after the clear so a same-cycle issue to the same register wins.
        if (set_en_i && !is_ro(set_addr_i)) begin
            pend_d[set_addr_i] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // A register is also hazardous while its write sits in the output stage.
    function automatic logic lookup(input rf_addr_t rd);
        return pend_q[rd] || (wr_en_i && (wr_addr_i == rd) && !is_ro(rd));
    endfunction

    assign haz_a_o     = lookup(rd_addr_a_i);
    assign haz_b_o     = lookup(rd_addr_b_i);
    assign pend_mask_o = pend_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// Loads normally win; an ALU that loses MAX_WAIT consecutive eligible
// cycles gets priority until it transfers. ALU writes to a register with
// a pending load are held off to keep write order.
// Ports:
//   alu_valid/addr/data/ready   ALU write-back handshake
//   ld_issue/ld_issue_addr      load issued, marks destination pending
//   ld_valid/addr/data/ready    load data return handshake
//   rd_addrA/B, hazA/B          decode hazard lookup
//   rf_wr_en/addr/data          registered write port (latency 1)
//   pend_mask                   pending-load scoreboard
//   drop_err                    one-cycle pulse, constant-register access dropped
module rf_wb_arbiter
    import rf_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_addr,
    input  logic [DATA_W-1:0]   alu_data,
    output logic                alu_ready,
    input  logic                ld_issue,
    input  logic [ADDR_W-1:0]   ld_issue_addr,
    input  logic                ld_valid,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [DATA_W-1:0]   ld_data,
    output logic                ld_ready,
    input  logic [ADDR_W-1:0]   rd_addrA,
    input  logic [ADDR_W-1:0]   rd_addrB,
    output logic                hazA,
    output logic                hazB,
    output logic                rf_wr_en,
    output logic [ADDR_W-1:0]   rf_wr_addr,
    output logic [DATA_W-1:0]   rf_wr_data,
    output logic [NUM_REGS-1:0] pend_mask,
    output logic                drop_err
);

    prio_t     state_q, state_d;
    wait_cnt_t wait_cnt_q, wait_cnt_d;
    logic      rf_wr_en_q, drop_err_q;
    rf_addr_t  rf_wr_addr_q;
    rf_data_t  rf_wr_data_q;

    logic      alu_eligible, alu_xfer, ld_xfer, xfer, issue_drop;
    rf_addr_t  win_addr;
    rf_data_t  win_data;

    rf_scoreboard u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_en_i     (ld_issue),
        .set_addr_i   (ld_issue_addr),
        .clr_en_i     (ld_xfer),
        .clr_addr_i   (ld_addr),
        .wr_en_i      (rf_wr_en_q),
        .wr_addr_i    (rf_wr_addr_q),
        .rd_addr_a_i  (rd_addrA),
        .rd_addr_b_i  (rd_addrB),
        .pend_mask_o  (pend_mask),
        .haz_a_o      (hazA),
        .haz_b_o      (hazB),
        .issue_drop_o (issue_drop)
    );

    assign alu_eligible = alu_valid && !pend_mask[alu_addr];

    // Grant outputs. Both policies grant at most one requester per cycle.
    always_comb begin
        alu_ready = 1'b0;
        ld_ready  = 1'b0;
        unique case (state_q)
            LD_PRIO: begin
                ld_ready  = ld_valid;
                alu_ready = alu_eligible && !ld_valid;
            end
            ALU_PRIO: begin
                alu_ready = alu_eligible;
                ld_ready  = ld_valid && !alu_eligible;
            end
            default: ;
        endcase
    end

    assign alu_xfer = alu_valid && alu_ready;
    assign ld_xfer  = ld_valid && ld_ready;
    assign xfer     = alu_xfer || ld_xfer;
    assign win_addr = alu_xfer ? alu_addr : ld_addr;
    assign win_data = alu_xfer ? alu_data : ld_data;

    // Counts consecutive eligible-but-not-granted ALU cycles, saturating.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (alu_xfer) begin
            wait_cnt_d = '0;
        end else if (alu_eligible && !alu_ready && (wait_cnt_q != wait_cnt_t'(MAX_WAIT))) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Priority flips on the same edge the counter reaches MAX_WAIT, so the
    // ALU wins the cycle right after its MAX_WAIT-th loss.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LD_PRIO:  if (wait_cnt_d == wait_cnt_t'(MAX_WAIT)) state_d = ALU_PRIO;
            ALU_PRIO: if (alu_xfer) state_d = LD_PRIO;
            default:  state_d = LD_PRIO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LD_PRIO;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Write port: constant-register transfers are accepted but turned into
    // a drop pulse; address/data hold when nothing is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr_en_q   <= 1'b0;
            rf_wr_addr_q <= '0;
            rf_wr_data_q <= '0;
            drop_err_q   <= 1'b0;
        end else begin
            rf_wr_en_q <= xfer && !is_ro(win_addr);
            if (xfer && !is_ro(win_addr)) begin
                rf_wr_addr_q <= win_addr;
                rf_wr_data_q <= win_data;
            end
            drop_err_q <= (xfer && is_ro(win_addr)) || issue_drop;
        end
    end

    assign rf_wr_en   = rf_wr_en_q;
    assign rf_wr_addr = rf_wr_addr_q;
    assign rf_wr_data = rf_wr_data_q;
    assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed steps followed by random
// traffic, every cycle compared against a behavioural model.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, ld_issue, ld_valid;
    logic [2:0]  alu_addr, ld_issue_addr, ld_addr, rd_addrA, rd_addrB;
    logic [7:0]  alu_data, ld_data;
    logic        alu_ready, ld_ready, hazA, hazB, rf_wr_en, drop_err;
    logic [2:0]  rf_wr_addr;
    logic [7:0]  rf_wr_data;
    logic [7:0]  pend_mask;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] m_pend;
    int         m_loss;       // eligible ALU cycles lost since its last grant
    logic       m_wr_en;
    logic [2:0] m_wr_addr;
    logic [7:0] m_wr_data;
    logic       m_drop;
    logic       g_alu, g_ld;  // model grants of the current step

    rf_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_issue(ld_issue), .ld_issue_addr(ld_issue_addr),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .hazA(hazA), .hazB(hazB),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .pend_mask(pend_mask), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        ld_issue = 0; ld_issue_addr = 0;
        ld_valid = 0; ld_addr = 0; ld_data = 0;
        rd_addrA = 0; rd_addrB = 0;
    endtask

    task automatic model_reset();
        m_pend = 0; m_loss = 0; m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0; m_drop = 0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_wr_en"},   32'(rf_wr_en),   0);
        check({tag, "_wr_addr"}, 32'(rf_wr_addr), 0);
        check({tag, "_wr_data"}, 32'(rf_wr_data), 0);
        check({tag, "_pend"},    32'(pend_mask),  0);
        check({tag, "_drop"},    32'(drop_err),   0);
        check({tag, "_hazA"},    32'(hazA),       0);
        check({tag, "_hazB"},    32'(hazB),       0);
    endtask

    // Called at posedge+1 with inputs already set. Checks the cycle against
    // the model, then advances over the next rising edge.
    task automatic step(input string tag);
        logic elig, hA, hB, g;
        logic [2:0] wa;
        logic [7:0] wd;
        #3;
        elig = alu_valid && !m_pend[alu_addr];
        if (m_loss >= MAX_WAIT) begin
            g_alu = elig;
            g_ld  = ld_valid && !elig;
        end else begin
            g_ld  = ld_valid;
            g_alu = elig && !ld_valid;
        end
        hA = m_pend[rd_addrA] || (m_wr_en && m_wr_addr == rd_addrA && int'(rd_addrA) >= NUM_RO);
        hB = m_pend[rd_addrB] || (m_wr_en && m_wr_addr == rd_addrB && int'(rd_addrB) >= NUM_RO);
        check({tag, "_alu_ready"}, 32'(alu_ready),  32'(g_alu));
        check({tag, "_ld_ready"},  32'(ld_ready),   32'(g_ld));
        check({tag, "_hazA"},      32'(hazA),       32'(hA));
        check({tag, "_hazB"},      32'(hazB),       32'(hB));
        check({tag, "_wr_en"},     32'(rf_wr_en),   32'(m_wr_en));
        check({tag, "_wr_addr"},   32'(rf_wr_addr), 32'(m_wr_addr));
        check({tag, "_wr_data"},   32'(rf_wr_data), 32'(m_wr_data));
        check({tag, "_pend"},      32'(pend_mask),  32'(m_pend));
        check({tag, "_drop"},      32'(drop_err),   32'(m_drop));
        @(posedge clk);
        #1;
        // Advance the model using the inputs that were present at the edge.
        if (g_alu) m_loss = 0;
        else if (elig && m_loss < MAX_WAIT) m_loss = m_loss + 1;
        g  = g_alu || g_ld;
        wa = g_alu ? alu_addr : ld_addr;
        wd = g_alu ? alu_data : ld_data;
        m_wr_en = g && int'(wa) >= NUM_RO;
        if (m_wr_en) begin
            m_wr_addr = wa;
            m_wr_data = wd;
        end
        m_drop = (g && int'(wa) < NUM_RO) || (ld_issue && int'(ld_issue_addr) < NUM_RO);
        if (g_ld) m_pend[ld_addr] = 1'b0;
        if (ld_issue && int'(ld_issue_addr) >= NUM_RO) m_pend[ld_issue_addr] = 1'b1;
    endtask

    initial begin
        logic [4:0] ld_win_pat;
        ld_win_pat = 5'b10111;   // bit i: load wins cycle i

        // Power-on reset
        rst_n = 0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_checks("por");
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;

        // Build pend_mask=0x30 with a write in flight, then reset mid-operation
        idle(); ld_issue = 1; ld_issue_addr = 4; step("pre_rst0");
        idle(); ld_issue = 1; ld_issue_addr = 5;
        alu_valid = 1; alu_addr = 6; alu_data = 8'h11; step("pre_rst1");
        idle(); rd_addrA = 4; rd_addrB = 5;
        #1;
        check("pre_rst_pend", 32'(pend_mask), 32'h30);
        check("pre_rst_wren", 32'(rf_wr_en), 1);
        rst_n = 0;
        #1;
        model_reset();
        reset_checks("mid_rst");
        check("mid_rst_alu_ready", 32'(alu_ready), 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;

        // Lone ALU write, visible for exactly one cycle
        idle(); alu_valid = 1; alu_addr = 5; alu_data = 8'h3C; step("alu_w");
        idle(); step("alu_w1");
        check("alu_w_once", 32'(rf_wr_en), 0);
        step("alu_w2");

        // Load and ALU held: load wins 0,1,2, ALU wins 3, load wins 4
        for (int i = 0; i < 5; i++) begin
            idle();
            ld_valid = 1; ld_addr = 3; ld_data = 8'(8'h40 + i);
            alu_valid = 1; alu_addr = 6; alu_data = 8'h66;
            #2;
            check($sformatf("starve_ld_c%0d", i), 32'(ld_ready), 32'(ld_win_pat[i]));
            check($sformatf("starve_alu_c%0d", i), 32'(alu_ready), 32'(!ld_win_pat[i]));
            step($sformatf("starve%0d", i));
        end
        idle(); step("starve_end");

        // Pending-load sequence on register 4
        idle(); ld_issue = 1; ld_issue_addr = 4; step("pl_issue");
        idle(); rd_addrA = 4; step("pl_haz");
        idle(); rd_addrA = 4; alu_valid = 1; alu_addr = 4; alu_data = 8'h99; step("pl_alu_stall");
        ld_valid = 1; ld_addr = 4; ld_data = 8'h77; step("pl_ld_ret");
        ld_valid = 0;
        #1;
        check("pl_ret_data", 32'(rf_wr_data), 32'h77);
        check("pl_ret_hazA", 32'(hazA), 1);
        step("pl_after");
        idle(); rd_addrA = 4; step("pl_alu_done");
        idle(); step("pl_idle");

        // Constant-register guard
        idle(); alu_valid = 1; alu_addr = 1; alu_data = 8'hFF; step("ro_alu");
        idle(); ld_issue = 1; ld_issue_addr = 0; step("ro_alu_drop");
        idle(); step("ro_issue_drop");
        step("ro_quiet");

        // Issue and load return to the same register in one cycle: set wins
        idle(); ld_issue = 1; ld_issue_addr = 7; step("sc_issue");
        idle(); ld_issue = 1; ld_issue_addr = 7;
        ld_valid = 1; ld_addr = 7; ld_data = 8'h5A; step("sc_both");
        idle();
        #1;
        check("sc_pend7", 32'(pend_mask[7]), 1);
        step("sc_after");

        // Random traffic; requesters hold addr/data while valid && !ready
        idle();
        for (int c = 0; c < 400; c++) begin
            if (!(alu_valid && !g_alu) || c == 0) begin
                alu_valid = ($urandom_range(0, 99) < 60);
                alu_addr  = 3'($urandom_range(0, 7));
                alu_data  = 8'($urandom);
            end
            if (!(ld_valid && !g_ld) || c == 0) begin
                ld_valid = ($urandom_range(0, 99) < 45);
                ld_addr  = 3'($urandom_range(0, 7));
                ld_data  = 8'($urandom);
            end
            ld_issue      = ($urandom_range(0, 99) < 30);
            ld_issue_addr = 3'($urandom_range(0, 7));
            rd_addrA      = 3'($urandom_range(0, 7));
            rd_addrB      = 3'($urandom_range(0, 7));
            step($sformatf("rnd%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
